// File: rtl/t02_servo_bank.sv
// Multi-channel servo PWM bank: targets loaded over valid/ready, actual duty slews once per frame.
// Pulse registered (starts cycle after frame_start); load_ready always 1; watchdog under T02_SERVO_WDOG_EN.
module t02_servo_bank #(
  parameter int NUM_CH        = 2,
  parameter int DUTY_W        = 8,
  parameter int FRAME_TICKS   = 200000,
  parameter int MIN_TICKS     = 10000,
  parameter int TICKS_PER_LSB = 39,
  parameter int STEP_MAX      = 4,
  parameter int CENTER        = 128,
  parameter int WDOG_FRAMES   = 50,
  localparam int CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     en,
  input  logic                     load_valid,
  input  logic [CW-1:0]            load_ch,
  input  logic [DUTY_W-1:0]        load_duty,
  output logic                     load_ready,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*DUTY_W-1:0] actual_duty,
  output logic [NUM_CH-1:0]        at_target,
  output logic                     frame_start,
  output logic [NUM_CH-1:0]        wdog_trip
);

  localparam int     FCW       = $clog2(FRAME_TICKS);
  localparam longint MAX_WIDTH = longint'(MIN_TICKS) +
                                 longint'((1 << DUTY_W) - 1) * longint'(TICKS_PER_LSB);

  // The longest pulse must end before the frame wraps, or pulses would merge across frames.
  if (MAX_WIDTH >= longint'(FRAME_TICKS) || WDOG_FRAMES < 1) begin : g_bad_params
    $error("t02_servo_bank: maximum pulse width must be below FRAME_TICKS and WDOG_FRAMES >= 1");
  end

  logic [FCW-1:0]    r_cnt;
  logic [DUTY_W-1:0] r_target [NUM_CH];
  logic [DUTY_W-1:0] r_actual [NUM_CH];
  logic [DUTY_W-1:0] w_slew   [NUM_CH];
  logic [DUTY_W-1:0] w_act_nxt[NUM_CH];
  logic [31:0]       w_width  [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;
  logic [NUM_CH-1:0] w_pwm_nxt;
  logic [NUM_CH-1:0] w_load_hit;
  logic [NUM_CH-1:0] w_wdog_fire;
  logic              w_frame_start;
  logic              w_load_ok;

  assign w_frame_start = en && (r_cnt == '0);
  assign w_load_ok     = load_valid && (32'(load_ch) < NUM_CH);

  assign load_ready  = 1'b1;
  assign frame_start = w_frame_start;
  assign pwm_out     = r_pwm;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (!en || r_cnt == FCW'(FRAME_TICKS - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Slew step toward target, clamped to STEP_MAX; the clamp only engages when the
  // gap exceeds STEP_MAX, so the add/subtract can never wrap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_slew[i] = r_target[i];
      if (r_target[i] > r_actual[i]) begin
        if (32'(r_target[i] - r_actual[i]) > STEP_MAX) begin
          w_slew[i] = r_actual[i] + DUTY_W'(STEP_MAX);
        end
      end else if (32'(r_actual[i] - r_target[i]) > STEP_MAX) begin
        w_slew[i] = r_actual[i] - DUTY_W'(STEP_MAX);
      end
      w_act_nxt[i]  = w_frame_start ? w_slew[i] : r_actual[i];
      w_width[i]    = 32'(MIN_TICKS) + 32'(w_act_nxt[i]) * 32'(TICKS_PER_LSB);
      w_pwm_nxt[i]  = en && (32'(r_cnt) < w_width[i]);
      w_load_hit[i] = w_load_ok && (load_ch == CW'(i));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pwm <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_target[i] <= DUTY_W'(CENTER);
        r_actual[i] <= DUTY_W'(CENTER);
      end
    end else begin
      r_pwm <= w_pwm_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_frame_start) begin
          r_actual[i] <= w_slew[i];
        end
        if (w_load_hit[i]) begin
          r_target[i] <= load_duty;
        end else if (w_wdog_fire[i]) begin
          r_target[i] <= DUTY_W'(CENTER);
        end
      end
    end
  end

`ifdef T02_SERVO_WDOG_EN
  localparam int WCW = $clog2(WDOG_FRAMES + 1);

  logic [WCW-1:0]    r_wdog_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_trip;

  // Fires on the frame_start that brings the idle count up to WDOG_FRAMES.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_wdog_fire[i] = w_frame_start && !r_trip[i] &&
                       (r_wdog_cnt[i] == WCW'(WDOG_FRAMES - 1));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_trip <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_wdog_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_load_hit[i]) begin
          r_wdog_cnt[i] <= '0;
          r_trip[i]     <= 1'b0;
        end else if (w_frame_start && !r_trip[i]) begin
          r_wdog_cnt[i] <= r_wdog_cnt[i] + 1'b1;
          r_trip[i]     <= w_wdog_fire[i];
        end
      end
    end
  end

  assign wdog_trip = r_trip;
`else
  assign w_wdog_fire = '0;
  assign wdog_trip   = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      actual_duty[i*DUTY_W +: DUTY_W] = r_actual[i];
      at_target[i]                    = (r_actual[i] == r_target[i]);
    end
  end

endmodule
